multicycle_control: RTL and testbench

MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

---
 rtl/multicycle_control_if.sv | 33 +++
 rtl/multicycle_control.sv | 136 +++++++++++++
 tb/tb_multicycle_control.sv | 209 ++++++++++++++++++++
 3 files changed

// File: rtl/multicycle_control_if.sv
// Control bundle between the datapath and the multicycle control FSM.
// The datapath/bench side is the master (drives Run, opcode and Zero);
// the controller is the slave (drives every control strobe).
interface multicycle_control_if;
  logic        Run;
  logic [10:0] OpCodefield;
  logic        Zero;
  logic        IRWrite;
  logic        PCWrite;
  logic        PCSource;
  logic        Reg2Loc;
  logic [1:0]  ALUOp;
  logic [1:0]  AluSrc;
  logic        MemRead;
  logic        MemWrite;
  logic        memtoReg;
  logic        RegWrite;
  logic        Busy;
  logic        Error;
  logic [15:0] InstrCount;

  modport master (
    output Run, OpCodefield, Zero,
    input  IRWrite, PCWrite, PCSource, Reg2Loc, ALUOp, AluSrc,
           MemRead, MemWrite, memtoReg, RegWrite, Busy, Error, InstrCount
  );

  modport slave (
    input  Run, OpCodefield, Zero,
    output IRWrite, PCWrite, PCSource, Reg2Loc, ALUOp, AluSrc,
           MemRead, MemWrite, memtoReg, RegWrite, Busy, Error, InstrCount
  );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle control unit for a small ARM-style datapath (R-type, LDUR,
// STUR, CBZ, B). One state per cycle; strobes are decoded from the state
// register. InstrCount counts instructions that reach a retiring state.
module multicycle_control (
  input logic                  clock,
  input logic                  reset,
  multicycle_control_if.slave  bus
);

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_EXEC_R, S_MEM_ADDR, S_MEM_RD,
    S_WB_LD, S_MEM_WR, S_WB_R, S_BR_CBZ, S_BR_B, S_ILLEGAL
  } state_t;

  localparam logic [10:0] OP_ADD  = 11'h458;
  localparam logic [10:0] OP_SUB  = 11'h658;
  localparam logic [10:0] OP_AND  = 11'h450;
  localparam logic [10:0] OP_ORR  = 11'h550;
  localparam logic [10:0] OP_LDUR = 11'h7C2;
  localparam logic [10:0] OP_STUR = 11'h7C0;

  state_t      state_q, state_d;
  logic        is_ldur_q, is_ldur_d;   // memory class captured in DECODE
  logic [15:0] count_q, count_d;

  logic op_rtype, op_ldur, op_stur, op_cbz, op_b;

  // Opcode class decode from the live opcode field (only consumed in DECODE)
  always_comb begin
    op_rtype = (bus.OpCodefield == OP_ADD) || (bus.OpCodefield == OP_SUB) ||
               (bus.OpCodefield == OP_AND) || (bus.OpCodefield == OP_ORR);
    op_ldur  = (bus.OpCodefield == OP_LDUR);
    op_stur  = (bus.OpCodefield == OP_STUR);
    op_cbz   = (bus.OpCodefield[10:3] == 8'hB4);
    op_b     = (bus.OpCodefield[10:5] == 6'h05);
  end

  // State, captured memory class and retired-instruction counter
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q   <= S_IDLE;
      is_ldur_q <= 1'b0;
      count_q   <= 16'd0;
    end else begin
      state_q   <= state_d;
      is_ldur_q <= is_ldur_d;
      count_q   <= count_d;
    end
  end

  // Next-state and counter update
  always_comb begin
    state_d   = state_q;
    is_ldur_d = is_ldur_q;
    count_d   = count_q;
    case (state_q)
      S_IDLE:     if (bus.Run) state_d = S_FETCH;
      S_FETCH:    state_d = S_DECODE;
      S_DECODE: begin
        is_ldur_d = op_ldur;
        if (op_rtype)                state_d = S_EXEC_R;
        else if (op_ldur || op_stur) state_d = S_MEM_ADDR;
        else if (op_cbz)             state_d = S_BR_CBZ;
        else if (op_b)               state_d = S_BR_B;
        else                         state_d = S_ILLEGAL;
      end
      S_EXEC_R:   state_d = S_WB_R;
      S_MEM_ADDR: state_d = is_ldur_q ? S_MEM_RD : S_MEM_WR;
      S_MEM_RD:   state_d = S_WB_LD;
      S_WB_R, S_WB_LD, S_MEM_WR, S_BR_CBZ, S_BR_B: begin
        state_d = S_FETCH;
        count_d = count_q + 16'd1;   // wraps naturally at 0xFFFF
      end
      S_ILLEGAL:  state_d = S_ILLEGAL;
      default:    state_d = S_IDLE;
    endcase
  end

  // Control strobes decoded from the current state. DECODE's Reg2Loc and
  // BR_CBZ's PCWrite are the only ones qualified by an input, because the
  // opcode and Zero only become valid in those very cycles.
  always_comb begin
    bus.IRWrite  = 1'b0;
    bus.PCWrite  = 1'b0;
    bus.PCSource = 1'b0;
    bus.Reg2Loc  = 1'b0;
    bus.ALUOp    = 2'b00;
    bus.AluSrc   = 2'b00;
    bus.MemRead  = 1'b0;
    bus.MemWrite = 1'b0;
    bus.memtoReg = 1'b0;
    bus.RegWrite = 1'b0;
    bus.Busy     = (state_q != S_IDLE) && (state_q != S_ILLEGAL);
    bus.Error    = (state_q == S_ILLEGAL);
    case (state_q)
      S_FETCH: begin
        bus.IRWrite = 1'b1;
        bus.PCWrite = 1'b1;
      end
      S_DECODE:   bus.Reg2Loc = op_stur || op_cbz;
      S_EXEC_R:   bus.ALUOp = 2'b10;
      S_MEM_ADDR: bus.AluSrc = 2'b01;
      S_MEM_RD: begin
        bus.MemRead = 1'b1;
        bus.AluSrc  = 2'b01;
      end
      S_WB_LD: begin
        bus.RegWrite = 1'b1;
        bus.memtoReg = 1'b1;
      end
      S_MEM_WR: begin
        bus.MemWrite = 1'b1;
        bus.AluSrc   = 2'b01;
        bus.Reg2Loc  = 1'b1;
      end
      S_WB_R: begin
        bus.RegWrite = 1'b1;
        bus.ALUOp    = 2'b10;
      end
      S_BR_CBZ: begin
        bus.ALUOp    = 2'b01;
        bus.Reg2Loc  = 1'b1;
        bus.PCSource = 1'b1;
        bus.PCWrite  = bus.Zero;
      end
      S_BR_B: begin
        bus.PCWrite  = 1'b1;
        bus.PCSource = 1'b1;
      end
      default: ;
    endcase
  end

  assign bus.InstrCount = count_q;

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: table of instructions run
// back-to-back with per-cycle expected strobe words queued in a scoreboard,
// plus hand sequences for reset-in-flight, the sticky illegal state and
// the InstrCount wrap.
module tb_multicycle_control;

  logic clock = 1'b0;
  logic reset = 1'b1;
  always #5 clock = ~clock;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus.slave)
  );

  typedef enum int {C_R, C_LD, C_ST, C_CBZ, C_B} cls_t;

  typedef struct {
    string       name;
    logic [10:0] op;
    logic        zero;
    cls_t        cls;
    int          lat;
  } vec_t;

  int checks = 0;
  int errors = 0;
  logic [15:0] model_count = 16'd0;
  logic [13:0] sb [$];

  // Word layout: {IRWrite,PCWrite,PCSource,Reg2Loc,ALUOp,AluSrc,
  //               MemRead,MemWrite,memtoReg,RegWrite,Busy,Error}
  function automatic logic [13:0] mk(logic ir, logic pcw, logic pcs, logic r2l,
                                     logic [1:0] aop, logic [1:0] asrc,
                                     logic mr, logic mw, logic m2r, logic rw,
                                     logic busy, logic err);
    return {ir, pcw, pcs, r2l, aop, asrc, mr, mw, m2r, rw, busy, err};
  endfunction

  function automatic logic [13:0] dut_word();
    return {bus.IRWrite, bus.PCWrite, bus.PCSource, bus.Reg2Loc, bus.ALUOp,
            bus.AluSrc, bus.MemRead, bus.MemWrite, bus.memtoReg, bus.RegWrite,
            bus.Busy, bus.Error};
  endfunction

  task automatic check(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Queue the per-cycle strobe words one instruction should produce
  task automatic push_expected(cls_t cls, logic zero);
    sb.push_back(mk(1,1,0,0,2'b00,2'b00,0,0,0,0,1,0));                       // FETCH
    sb.push_back(mk(0,0,0,(cls == C_ST || cls == C_CBZ),2'b00,2'b00,0,0,0,0,1,0)); // DECODE
    case (cls)
      C_R: begin
        sb.push_back(mk(0,0,0,0,2'b10,2'b00,0,0,0,0,1,0));
        sb.push_back(mk(0,0,0,0,2'b10,2'b00,0,0,0,1,1,0));
      end
      C_LD: begin
        sb.push_back(mk(0,0,0,0,2'b00,2'b01,0,0,0,0,1,0));
        sb.push_back(mk(0,0,0,0,2'b00,2'b01,1,0,0,0,1,0));
        sb.push_back(mk(0,0,0,0,2'b00,2'b00,0,0,1,1,1,0));
      end
      C_ST: begin
        sb.push_back(mk(0,0,0,0,2'b00,2'b01,0,0,0,0,1,0));
        sb.push_back(mk(0,0,0,1,2'b00,2'b01,0,1,0,0,1,0));
      end
      C_CBZ: sb.push_back(mk(0,zero,1,1,2'b01,2'b00,0,0,0,0,1,0));
      C_B:   sb.push_back(mk(0,1,1,0,2'b00,2'b00,0,0,0,0,1,0));
      default: ;
    endcase
  endtask

  // Run one instruction starting at its FETCH cycle; pops one word per cycle
  task automatic run_vec(vec_t v, int stop_at);
    logic [13:0] exp;
    push_expected(v.cls, v.zero);
    for (int c = 0; c < v.lat; c++) begin
      @(negedge clock);
      exp = sb.pop_front();
      check($sformatf("%s_c%0d", v.name, c + 1), {2'b00, dut_word()}, {2'b00, exp});
      if (c == 0) begin
        check($sformatf("%s_count", v.name), bus.InstrCount, model_count);
        bus.OpCodefield = v.op;
        bus.Zero        = v.zero;
        bus.Run         = 1'b0;               // ignored once running
      end
      if (c == 2) bus.OpCodefield = v.op ^ 11'h002; // late change must not matter
      if (c == stop_at) begin
        sb.delete();
        return;
      end
    end
    model_count = model_count + 16'd1;
    $display("instr %-8s op=%h zero=%0d lat=%0d count_after=%0d",
             v.name, v.op, v.zero, v.lat, model_count);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset   = 1'b1;
    bus.Run = 1'b0;
    @(negedge clock);
    check("reset_word", {2'b00, dut_word()}, 16'h0000);
    check("reset_count", bus.InstrCount, 16'h0000);
    reset       = 1'b0;
    model_count = 16'd0;
  endtask

  vec_t vecs [10];

  initial begin
    bus.Run = 1'b0;
    bus.OpCodefield = 11'h000;
    bus.Zero = 1'b0;

    vecs[0] = '{"ADD",    11'h458, 1'b0, C_R,   4};
    vecs[1] = '{"SUB",    11'h658, 1'b1, C_R,   4};
    vecs[2] = '{"AND",    11'h450, 1'b0, C_R,   4};
    vecs[3] = '{"ORR",    11'h550, 1'b0, C_R,   4};
    vecs[4] = '{"LDUR",   11'h7C2, 1'b0, C_LD,  5};
    vecs[5] = '{"STUR",   11'h7C0, 1'b1, C_ST,  4};
    vecs[6] = '{"CBZ_Z0", 11'h5A0, 1'b0, C_CBZ, 3};
    vecs[7] = '{"CBZ_Z1", 11'h5A7, 1'b1, C_CBZ, 3};
    vecs[8] = '{"B_LO",   11'h0A0, 1'b0, C_B,   3};
    vecs[9] = '{"B_HI",   11'h0BF, 1'b1, C_B,   3};

    repeat (2) @(posedge clock);
    do_reset();

    // Idle with Run low must not start
    @(negedge clock);
    check("idle_hold", {2'b00, dut_word()}, 16'h0000);

    // Back-to-back table run
    bus.Run = 1'b1;
    foreach (vecs[i]) run_vec(vecs[i], -1);
    @(negedge clock);
    check("table_final_count", bus.InstrCount, model_count);

    // Reset in the MEM_WR cycle of a STUR (first instruction after reset)
    do_reset();
    bus.Run = 1'b1;
    bus.OpCodefield = 11'h7C0;
    run_vec(vecs[5], 3);
    reset = 1'b1;
    @(negedge clock);
    check("rst_memwr_memwrite", {15'd0, bus.MemWrite}, 16'h0000);
    check("rst_memwr_word", {2'b00, dut_word()}, 16'h0000);
    check("rst_memwr_count", bus.InstrCount, 16'h0000);
    reset = 1'b0;
    bus.Run = 1'b0;
    $display("seq reset_in_MEM_WR count=%0d", bus.InstrCount);

    // Reset in WB_LD of an LDUR
    bus.Run = 1'b1;
    run_vec(vecs[4], 4);
    reset = 1'b1;
    @(negedge clock);
    check("rst_wbld_regwrite", {15'd0, bus.RegWrite}, 16'h0000);
    check("rst_wbld_count", bus.InstrCount, 16'h0000);
    reset = 1'b0;
    bus.Run = 1'b0;
    $display("seq reset_in_WB_LD count=%0d", bus.InstrCount);

    // Illegal opcode: sticky, Busy low, Run toggling has no effect
    do_reset();
    bus.Run = 1'b1;
    bus.OpCodefield = 11'h000;
    @(negedge clock);
    check("ill_fetch", {2'b00, dut_word()}, {2'b00, mk(1,1,0,0,2'b00,2'b00,0,0,0,0,1,0)});
    @(negedge clock);
    check("ill_decode", {2'b00, dut_word()}, {2'b00, mk(0,0,0,0,2'b00,2'b00,0,0,0,0,1,0)});
    for (int k = 0; k < 12; k++) begin
      @(negedge clock);
      check($sformatf("ill_hold_%0d", k), {2'b00, dut_word()},
            {2'b00, mk(0,0,0,0,2'b00,2'b00,0,0,0,0,0,1)});
      bus.Run = ~bus.Run;
      bus.OpCodefield = 11'($urandom);
    end
    check("ill_count", bus.InstrCount, 16'h0000);
    $display("seq illegal_sticky count=%0d", bus.InstrCount);
    do_reset();
    @(negedge clock);
    check("ill_exit_idle", {2'b00, dut_word()}, 16'h0000);

    // Counter wrap: 65535 B instructions, then one more
    bus.OpCodefield = 11'h0A0;
    bus.Run = 1'b1;
    repeat (65535 * 3 + 1) @(negedge clock);
    bus.Run = 1'b0;
    check("wrap_at_ffff", bus.InstrCount, 16'hFFFF);
    check("wrap_fetch_align", {15'd0, bus.IRWrite}, 16'h0001);
    repeat (3) @(negedge clock);
    check("wrap_to_zero", bus.InstrCount, 16'h0000);
    $display("seq wrap count=%0d", bus.InstrCount);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
